// File: rtl/ysyx_22041412_div_pkg.sv
// Shared definitions for the iterative RV64M divider: func3 codes and FSM states.
package ysyx_22041412_div_pkg;

    localparam logic [2:0] FUNC3_DIV  = 3'b100;
    localparam logic [2:0] FUNC3_DIVU = 3'b101;
    localparam logic [2:0] FUNC3_REM  = 3'b110;
    localparam logic [2:0] FUNC3_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic func3_is_signed(input logic [2:0] f3);
        return (f3 == FUNC3_DIV) || (f3 == FUNC3_REM);
    endfunction

    function automatic logic func3_is_rem(input logic [2:0] f3);
        return (f3 == FUNC3_REM) || (f3 == FUNC3_REMU);
    endfunction

endpackage

// File: rtl/ysyx_22041412_div_prep.sv
// Combinational operand preparation: W extension, magnitudes, sign flags and
// resolution of the cases that need no iteration (div by zero, overflow, illegal).
module ysyx_22041412_div_prep
    import ysyx_22041412_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            w_en,
    input  logic [XLEN-1:0] rsA,
    input  logic [XLEN-1:0] rsB,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] dvd_abs,
    output logic [XLEN-1:0] dvs_abs,
    output logic            neg_quo,
    output logic            neg_rem,
    output logic            is_rem,
    output logic            special,
    output logic [XLEN-1:0] special_result
);

    localparam int HALF = XLEN / 2;

    logic            is_signed_s;
    logic            legal_s;
    logic [XLEN-1:0] dvd_ext_s;
    logic [XLEN-1:0] dvs_ext_s;
    logic [XLEN-1:0] min_val_s;
    logic            dvd_neg_s;
    logic            dvs_neg_s;
    logic            div_zero_s;
    logic            overflow_s;

    // Operand extension, magnitude and sign decode.
    always_comb begin
        is_signed_s = func3_is_signed(func3);
        is_rem      = func3_is_rem(func3);
        legal_s     = func3[2];
        if (w_en) begin
            if (is_signed_s) begin
                dvd_ext_s = {{HALF{rsA[HALF-1]}}, rsA[HALF-1:0]};
                dvs_ext_s = {{HALF{rsB[HALF-1]}}, rsB[HALF-1:0]};
            end else begin
                dvd_ext_s = {{HALF{1'b0}}, rsA[HALF-1:0]};
                dvs_ext_s = {{HALF{1'b0}}, rsB[HALF-1:0]};
            end
            min_val_s = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end else begin
            dvd_ext_s = rsA;
            dvs_ext_s = rsB;
            min_val_s = {1'b1, {(XLEN-1){1'b0}}};
        end
        dvd_neg_s = is_signed_s & dvd_ext_s[XLEN-1];
        dvs_neg_s = is_signed_s & dvs_ext_s[XLEN-1];
        dvd_abs   = dvd_neg_s ? ({XLEN{1'b0}} - dvd_ext_s) : dvd_ext_s;
        dvs_abs   = dvs_neg_s ? ({XLEN{1'b0}} - dvs_ext_s) : dvs_ext_s;
        neg_quo   = dvd_neg_s ^ dvs_neg_s;
        neg_rem   = dvd_neg_s;
    end

    // Special-case detection; the special result is pre-W-fix (top applies it).
    always_comb begin
        div_zero_s = (dvs_ext_s == {XLEN{1'b0}});
        overflow_s = is_signed_s && (dvd_ext_s == min_val_s) &&
                     (dvs_ext_s == {XLEN{1'b1}});
        special    = !legal_s || div_zero_s || overflow_s;
        if (!legal_s) begin
            special_result = {XLEN{1'b0}};
        end else if (div_zero_s) begin
            special_result = is_rem ? dvd_ext_s : {XLEN{1'b1}};
        end else if (overflow_s) begin
            special_result = is_rem ? {XLEN{1'b0}} : dvd_ext_s;
        end else begin
            special_result = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/ysyx_22041412_div.sv
// Iterative radix-2 restoring divider for RV64M div/rem and W variants.
// One quotient bit per cycle; en is held by the ALU until the one-cycle ready pulse.
module ysyx_22041412_div
    import ysyx_22041412_div_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic            w_en,
    input  logic [XLEN-1:0] rsA,
    input  logic [XLEN-1:0] rsB,
    input  logic [2:0]      func3,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int HALF = XLEN / 2;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

    function automatic logic [XLEN-1:0] w_fix(input logic w, input logic [XLEN-1:0] v);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    div_state_e      state_r;
    div_state_e      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN-1:0] result_r;
    logic            neg_quo_r;
    logic            neg_rem_r;
    logic            is_rem_r;
    logic            w_r;
    logic            ready_r;

    logic [XLEN-1:0] dvd_abs_s;
    logic [XLEN-1:0] dvs_abs_s;
    logic            neg_quo_s;
    logic            neg_rem_s;
    logic            is_rem_s;
    logic            special_s;
    logic [XLEN-1:0] special_result_s;

    logic            start_s;
    logic            step_s;
    logic            load_result_s;
    logic [XLEN-1:0] result_nxt_s;
    logic [XLEN:0]   rem_shift_s;
    logic [XLEN:0]   diff_s;
    logic [XLEN-1:0] rem_nxt_s;
    logic [XLEN-1:0] quo_nxt_s;
    logic [XLEN-1:0] quo_fin_s;
    logic [XLEN-1:0] rem_fin_s;

    ysyx_22041412_div_prep #(.XLEN(XLEN)) u_prep (
        .w_en           (w_en),
        .rsA            (rsA),
        .rsB            (rsB),
        .func3          (func3),
        .dvd_abs        (dvd_abs_s),
        .dvs_abs        (dvs_abs_s),
        .neg_quo        (neg_quo_s),
        .neg_rem        (neg_rem_s),
        .is_rem         (is_rem_s),
        .special        (special_s),
        .special_result (special_result_s)
    );

    // One restoring step and the signed fix-up of the would-be final values.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_r};
        if (diff_s[XLEN] == 1'b0) begin
            rem_nxt_s = diff_s[XLEN-1:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_shift_s[XLEN-1:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
        end
        quo_fin_s = neg_quo_r ? ({XLEN{1'b0}} - quo_nxt_s) : quo_nxt_s;
        rem_fin_s = neg_rem_r ? ({XLEN{1'b0}} - rem_nxt_s) : rem_nxt_s;
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s   = state_r;
        start_s       = 1'b0;
        step_s        = 1'b0;
        load_result_s = 1'b0;
        result_nxt_s  = result_r;
        case (state_r)
            DIV_IDLE: begin
                if (flush) begin
                    state_nxt_s = DIV_IDLE;
                end else if (en) begin
                    start_s = 1'b1;
                    if (special_s) begin
                        state_nxt_s   = DIV_DONE;
                        load_result_s = 1'b1;
                        result_nxt_s  = w_fix(w_en, special_result_s);
                    end else begin
                        state_nxt_s = DIV_CALC;
                    end
                end else begin
                    state_nxt_s = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                if (flush) begin
                    state_nxt_s = DIV_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s   = DIV_DONE;
                        load_result_s = 1'b1;
                        result_nxt_s  = w_fix(w_r, is_rem_r ? rem_fin_s : quo_fin_s);
                    end else begin
                        state_nxt_s = DIV_CALC;
                    end
                end
            end
            DIV_DONE: begin
                state_nxt_s = DIV_IDLE;
            end
            default: begin
                state_nxt_s = DIV_IDLE;
            end
        endcase
    end

    // State, ready pulse and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= DIV_IDLE;
            ready_r  <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == DIV_DONE);
            if (load_result_s) begin
                result_r <= result_nxt_s;
            end
        end
    end

    // Operand capture on start; W dividends are left-aligned so HALF steps suffice.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            is_rem_r  <= 1'b0;
            w_r       <= 1'b0;
        end else if (start_s) begin
            cnt_r     <= w_en ? CNT_HALF : CNT_FULL;
            quo_r     <= w_en ? {dvd_abs_s[HALF-1:0], {HALF{1'b0}}} : dvd_abs_s;
            rem_r     <= {XLEN{1'b0}};
            dvs_r     <= dvs_abs_s;
            neg_quo_r <= neg_quo_s;
            neg_rem_r <= neg_rem_s;
            is_rem_r  <= is_rem_s;
            w_r       <= w_en;
        end else if (step_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            quo_r <= quo_nxt_s;
            rem_r <= rem_nxt_s;
        end
    end

    assign ready  = ready_r;
    assign result = result_r;

endmodule

// File: tb/tb_ysyx_22041412_div.sv
// Scoreboard bench for ysyx_22041412_div: driver pushes expected result/latency from
// a plain-arithmetic model, a negedge monitor pops and compares on every ready.
module tb_ysyx_22041412_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic        w_en;
    logic [63:0] rsA;
    logic [63:0] rsB;
    logic [2:0]  func3;
    logic        ready;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        int          start;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ready_seen = 0;
    logic        prev_ready = 1'b0;
    logic [63:0] last_res = 64'd0;

    ysyx_22041412_div #(.XLEN(64), .CNT_W(7)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .flush  (flush),
        .w_en   (w_en),
        .rsA    (rsA),
        .rsB    (rsB),
        .func3  (func3),
        .ready  (ready),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, got, expv);
        end
    endtask

    // Reference: RISC-V M-extension semantics with plain signed/unsigned arithmetic.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] f3, input logic w,
                                  output logic [63:0] r, output int lat);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] sa32;
        logic signed [31:0] sb32;
        logic [31:0]        ua32;
        logic [31:0]        ub32;
        logic [31:0]        r32;
        logic               sgn;
        logic               remop;
        sgn   = !f3[0];
        remop = f3[1];
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        if (!f3[2]) begin
            r = 64'd0; lat = 1;
        end else if (w) begin
            lat = 33;
            if (ub32 == 32'd0) begin
                r32 = remop ? ua32 : 32'hFFFFFFFF; lat = 1;
            end else if (sgn && sa32 == 32'sh80000000 && sb32 == 32'shFFFFFFFF) begin
                r32 = remop ? 32'd0 : ua32; lat = 1;
            end else if (sgn) begin
                r32 = remop ? sa32 % sb32 : sa32 / sb32;
            end else begin
                r32 = remop ? ua32 % ub32 : ua32 / ub32;
            end
            r = {{32{r32[31]}}, r32};
        end else begin
            lat = 65;
            if (b == 64'd0) begin
                r = remop ? a : 64'hFFFFFFFFFFFFFFFF; lat = 1;
            end else if (sgn && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF) begin
                r = remop ? 64'd0 : a; lat = 1;
            end else if (sgn) begin
                r = remop ? sa % sb : sa / sb;
            end else begin
                r = remop ? a % b : a / b;
            end
        end
    endfunction

    task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                            input logic w, input int start);
        exp_t e;
        model(a, b, f3, w, e.res, e.lat);
        e.start = start;
        sb_q.push_back(e);
        last_res = e.res;
    endtask

    task automatic wait_ready(input logic drop_en, output logic got);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (drop_en) en = 1'b0;
            if (ready) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=none required=ready");
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                          input logic w, input logic drop_en);
        logic got;
        @(negedge clk);
        rsA = a; rsB = b; func3 = f3; w_en = w; en = 1'b1;
        push_exp(a, b, f3, w, cyc + 1);
        wait_ready(drop_en, got);
        en = 1'b0;
        rsA = {$urandom(), $urandom()};
        rsB = {$urandom(), $urandom()};
    endtask

    task automatic abort_op(input logic use_rst);
        @(negedge clk);
        rsA = 64'd100; rsB = 64'd7; func3 = 3'b101; w_en = 1'b0; en = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        if (use_rst) last_res = 64'd0;
        ready_seen = 0;
        repeat (80) @(negedge clk);
        chk(use_rst ? "rst_abort_no_ready" : "flush_no_ready", 64'(ready_seen), 64'd0);
        chk(use_rst ? "rst_abort_result" : "flush_result_held", result, last_res);
    endtask

    // Monitor: every ready pulse is one cycle wide and matches the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1) begin
            ready_seen++;
            chk("ready_width", 64'(prev_ready), 64'd0);
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ready actual=%h required=no_ready", result);
            end else begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("latency", 64'(cyc + 1 - e.start), 64'(e.lat));
            end
        end
        prev_ready <= (ready === 1'b1);
    end

    initial begin
        logic        got;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  f3;
        logic        w;
        rst = 1'b1; en = 1'b0; flush = 1'b0; w_en = 1'b0;
        rsA = 64'd0; rsB = 64'd0; func3 = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        run_op(64'd100, 64'd7, 3'b101, 1'b0, 1'b0);
        run_op(64'd100, 64'd7, 3'b111, 1'b0, 1'b0);
        run_op(64'hFFFFFFFFFFFFFFF9, 64'd2, 3'b100, 1'b0, 1'b0);
        run_op(64'hFFFFFFFFFFFFFFF9, 64'd2, 3'b110, 1'b0, 1'b1);
        run_op(64'd5, 64'd0, 3'b101, 1'b0, 1'b0);
        run_op(64'd5, 64'd0, 3'b111, 1'b0, 1'b0);
        run_op(64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 3'b100, 1'b0, 1'b0);
        run_op(64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 3'b110, 1'b0, 1'b0);
        run_op(64'h12345678FFFFFFFE, 64'hABCD000000000001, 3'b101, 1'b1, 1'b0);
        run_op(64'h0000000080000000, 64'h00000000FFFFFFFF, 3'b100, 1'b1, 1'b0);
        run_op(64'h64, 64'hA, 3'b110, 1'b1, 1'b0);
        run_op(64'd77, 64'd3, 3'b010, 1'b0, 1'b0);
        run_op(64'd100, 64'd7, 3'b111, 1'b0, 1'b0);

        abort_op(1'b0);
        abort_op(1'b1);

        // Back-to-back: en held through ready, new operands applied in the ready cycle.
        @(negedge clk);
        rsA = 64'd100; rsB = 64'd7; func3 = 3'b101; w_en = 1'b0; en = 1'b1;
        push_exp(64'd100, 64'd7, 3'b101, 1'b0, cyc + 1);
        wait_ready(1'b0, got);
        rsA = 64'd9; rsB = 64'd3; func3 = 3'b101;
        push_exp(64'd9, 64'd3, 3'b101, 1'b0, cyc + 2);
        @(negedge clk);
        wait_ready(1'b0, got);
        en = 1'b0;

        for (int i = 0; i < 60; i++) begin
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            w  = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            case ($urandom_range(0, 9))
                0: begin
                    if (w) b[31:0] = 32'd0; else b = 64'd0;
                end
                1: begin
                    if (w) begin
                        a[31:0] = 32'h80000000; b[31:0] = 32'hFFFFFFFF;
                    end else begin
                        a = 64'h8000000000000000; b = 64'hFFFFFFFFFFFFFFFF;
                    end
                end
                2: b = {b[63:32], 32'($urandom_range(1, 15))};
                3: b[63:32] = 32'd0;
                default: ;
            endcase
            run_op(a, b, f3, w, ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
